mul_seq_ctrl: RTL

Sequencing controller and two-port arbiter for the K-bit right-shift signed multiplier datapath. It arbitrates round-robin between two requesters that share one multiplier instance. For the granted requester, it issues the load / iterate / last-step strobes that drive the shift-add datapath, then returns a one-cycle completion pulse. It sits between the requesting units and the multiplier datapath and replaces free-running step counting with a request-driven handshake.

---
 rtl/mul_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: round-robin arbiter and load/step/last sequencer for a shared
// K-step right-shift signed multiplier datapath.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation; arbitrate among pending requests
// LOAD  | one cycle: datapath loads operands, clears accumulator
// RUN   | K iteration cycles; final one (cnt == K-1) is the sign step
// DONE  | one-cycle completion pulse to the granted requester
module mul_seq_ctrl #(
  parameter int K = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       dp_sel,
  output logic       dp_load,
  output logic       dp_step,
  output logic       dp_last,
  output logic [1:0] done
);

  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    gnt_q, gnt_nxt;
  logic          sel_q, sel_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic          win;

  // Winner index: a lone requester wins; on contention the one not served last.
  assign win = (req == 2'b10) || ((req == 2'b11) && !last_gnt);

  // State, step counter, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gnt_q    <= 2'b00;
      sel_q    <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gnt_q    <= gnt_nxt;
      sel_q    <= sel_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state logic; req is only looked at in IDLE, so a grant runs to completion.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gnt_nxt      = gnt_q;
    sel_nxt      = sel_q;
    last_gnt_nxt = last_gnt;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_nxt    = S_LOAD;
          sel_nxt      = win;
          gnt_nxt      = win ? 2'b10 : 2'b01;
          last_gnt_nxt = win;
        end
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        gnt_nxt   = 2'b00;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  // Moore output decode from registered state only.
  assign gnt     = gnt_q;
  assign busy    = (state != S_IDLE);
  assign dp_sel  = sel_q;
  assign dp_load = (state == S_LOAD);
  assign dp_step = (state == S_RUN);
  assign dp_last = dp_step && (cnt == CNT_LAST);
  assign done    = (state == S_DONE) ? gnt_q : 2'b00;

endmodule
